// File: rtl/nios2e_jtag_scan_pkg.sv
// Shared definitions for the Nios II virtual-JTAG scan driver:
// FSM state encoding, default widths and the debug-module IR codes.
package nios2e_jtag_scan_pkg;

  localparam int DR_W = 38;
  localparam int IR_W = 2;

  localparam logic [IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } scan_state_e;

endpackage

// File: rtl/nios2e_jtag_tck_gen.sv
// Divided test clock: each period opens with a falling edge, TCK_DIV clk low then TCK_DIV clk high.
// tck_fall_o/tck_rise_o flag the clk edge on which tck enters each level; disabling holds tck low.
module nios2e_jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic tck_fall_o,
  output logic tck_rise_o
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          started_q, started_d;
  logic          fall, rise;

  // The first enabled edge counts as a falling edge so the opening period starts immediately.
  assign fall = en_i && (cnt_q == '0) && (tck_q || !started_q);
  assign rise = en_i && (cnt_q == '0) && !tck_q && started_q;

  always_comb begin
    cnt_d     = cnt_q;
    tck_d     = tck_q;
    started_d = started_q;
    if (!en_i) begin
      cnt_d     = '0;
      tck_d     = 1'b0;
      started_d = 1'b0;
    end else if (fall) begin
      cnt_d     = CNT_RELOAD;
      tck_d     = 1'b0;
      started_d = 1'b1;
    end else if (rise) begin
      cnt_d     = CNT_RELOAD;
      tck_d     = 1'b1;
    end else begin
      cnt_d     = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      tck_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tck_q     <= tck_d;
      started_q <= started_d;
    end
  end

  assign tck_o      = tck_q;
  assign tck_fall_o = fall;
  assign tck_rise_o = rise;

endmodule

// File: rtl/nios2e_jtag_scan_driver.sv
// On-chip virtual-JTAG initiator: one UIR/CDR/SDR/UDR/RTI scan per command, captured DR returned.
// Build option NIOS2E_JTAG_SCAN_VARLEN_EN adds cmd_len for a per-command DR length.
//   state | meaning
//   IDLE  | ready for a command; after accept, waits for the first tck fall
//   UIR   | one period, ir_in updated on entry
//   CDR   | one period, capture-DR strobe
//   SDR   | L periods, tdi driven at falls, tdo shifted into the MSB at rises
//   UDR   | one period, update-DR strobe
//   RTI   | one period in run-test/idle
//   RESP  | tck stopped, rsp_valid held until rsp_ready
module nios2e_jtag_scan_driver
  import nios2e_jtag_scan_pkg::*;
#(
  parameter int DR_WIDTH = DR_W,
  parameter int IR_WIDTH = IR_W,
  parameter int TCK_DIV  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [IR_WIDTH-1:0]           cmd_ir,
  input  logic [DR_WIDTH-1:0]           cmd_dr,
`ifdef NIOS2E_JTAG_SCAN_VARLEN_EN
  input  logic [$clog2(DR_WIDTH+1)-1:0] cmd_len,
`endif
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DR_WIDTH-1:0]           rsp_data,
  output logic                          tck,
  output logic                          tdi,
  input  logic                          tdo,
  output logic [IR_WIDTH-1:0]           ir_in,
  output logic                          vs_uir,
  output logic                          vs_cdr,
  output logic                          vs_sdr,
  output logic                          vs_udr,
  output logic                          jtag_state_rti
);

  localparam int LW = $clog2(DR_WIDTH + 1);

  scan_state_e         state_q, state_d;
  logic [1:0]          rst_sync_q;
  logic                busy_q, busy_d;
  logic [IR_WIDTH-1:0] ir_lat_q, ir_lat_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]       bits_q, bits_d;
  logic                tdi_q, tdi_d;
  logic [LW-1:0]       len_w;
  logic [LW-1:0]       shamt;
  logic                tck_en, tck_fall, tck_rise, accept;

  assign cmd_ready = (state_q == IDLE) && !busy_q && rst_sync_q[1];
  assign accept    = cmd_valid && cmd_ready;
  assign tck_en    = busy_q && (state_q != RESP);

`ifdef NIOS2E_JTAG_SCAN_VARLEN_EN
  logic [LW-1:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (accept) len_d = (cmd_len > LW'(DR_WIDTH)) ? LW'(DR_WIDTH) : cmd_len;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) len_q <= '0;
    else          len_q <= len_d;
  end

  assign len_w = len_q;
`else
  assign len_w = LW'(DR_WIDTH);
`endif

  nios2e_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (tck_en),
    .tck_o      (tck),
    .tck_fall_o (tck_fall),
    .tck_rise_o (tck_rise)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ir_lat_d = ir_lat_q;
    ir_d     = ir_q;
    sr_d     = sr_q;
    bits_d   = bits_q;
    tdi_d    = tdi_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d   = 1'b1;
          ir_lat_d = cmd_ir;
          sr_d     = cmd_dr;
        end else if (tck_fall) begin
          state_d = UIR;
          ir_d    = ir_lat_q;
        end
      end
      UIR: if (tck_fall) state_d = CDR;
      CDR: begin
        if (tck_fall) begin
          if (len_w == '0) begin
            state_d = UDR;
          end else begin
            state_d = SDR;
            bits_d  = len_w - 1'b1;
            tdi_d   = sr_q[0];
          end
        end
      end
      SDR: begin
        if (tck_rise) begin
          sr_d = DR_WIDTH'({tdo, sr_q} >> 1);
        end else if (tck_fall) begin
          if (bits_q == '0) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            bits_d = bits_q - 1'b1;
            tdi_d  = sr_q[0];
          end
        end
      end
      UDR: if (tck_fall) state_d = RTI;
      RTI: if (tck_fall) state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Assertion is immediate; release reaches cmd_ready only after two clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      ir_lat_q <= '0;
      ir_q     <= '0;
      sr_q     <= '0;
      bits_q   <= '0;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      ir_lat_q <= ir_lat_d;
      ir_q     <= ir_d;
      sr_q     <= sr_d;
      bits_q   <= bits_d;
      tdi_q    <= tdi_d;
    end
  end

  assign shamt          = LW'(DR_WIDTH) - len_w;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_data       = (state_q == RESP) ? (sr_q >> shamt) : '0;
  assign tdi            = tdi_q;
  assign ir_in          = ir_q;
  assign vs_uir         = (state_q == UIR);
  assign vs_cdr         = (state_q == CDR);
  assign vs_sdr         = (state_q == SDR);
  assign vs_udr         = (state_q == UDR);
  assign jtag_state_rti = (state_q == IDLE) || (state_q == RTI);

endmodule
